// File: rtl/if_fetch_if.sv
// Instruction-memory bus between the fetch stage and instruction memory.
// One outstanding request: req/addr handshake with gnt, data returned
// later with rvalid/rdata.
interface if_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/if_fetch.sv
// Instruction-fetch stage of the xRV32I pipeline.
// Holds the PC, issues one-outstanding-request reads to instruction memory,
// buffers one response across a stall and kills in-flight responses on a
// redirect. inst_valid/inst_out/inst_pc feed the IF/ID register directly.
// Optional build macro FETCH_ALIGN_CHECK_EN: flag misaligned redirect
// targets and park the fetcher until the next redirect or reset. Without
// it redirect targets are force-aligned and fetch_misalign is tied low.
//
// state | meaning
// ------+------------------------------------------------------------
// REQ   | request pc on the bus, wait for grant
// WAIT  | granted, waiting for rvalid
// HOLD  | response parked in buffer while IF/ID is stalled
// DRAIN | response of a killed request still due, discard it
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_in,
  input  logic             redir_valid,
  input  logic [31:0]      redir_pc,
  if_fetch_if.master       bus,
  output logic             inst_valid,
  output logic [31:0]      inst_out,
  output logic [31:0]      inst_pc,
  output logic             fetch_misalign
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pc_inc;
  logic        vld_q, vld_d;
  logic [31:0] out_q, out_d;
  logic [31:0] ipc_q, ipc_d;
  logic [31:0] buf_inst_q, buf_inst_d;
  logic [31:0] buf_pc_q, buf_pc_d;
  logic        req;
  logic        outstanding;
  logic        fetch_block;
  logic [31:0] redir_tgt;

`ifdef FETCH_ALIGN_CHECK_EN
  logic mis_q, mis_d;
  logic redir_mis;

  // Misaligned targets are kept as-is and block fetching until cleared.
  assign redir_tgt      = redir_pc;
  assign redir_mis      = |redir_pc[1:0];
  assign fetch_block    = mis_q;
  assign fetch_misalign = mis_q;
`else
  logic unused_redir_lsb;

  // Low address bits are dropped, so the target is always word aligned.
  assign redir_tgt        = {redir_pc[31:2], 2'b00};
  assign unused_redir_lsb = |redir_pc[1:0];
  assign fetch_block      = 1'b0;
  assign fetch_misalign   = 1'b0;
`endif

  assign pc_inc        = pc_q + 32'd4;
  assign req           = (state_q == S_REQ) && !fetch_block;
  assign bus.imem_req  = req;
  assign bus.imem_addr = pc_q;

  assign inst_valid = vld_q;
  assign inst_out   = out_q;
  assign inst_pc    = ipc_q;

  // A response is still owed by memory after this edge: a redirect must drain it.
  assign outstanding = ((state_q == S_WAIT)  && !bus.imem_rvalid) ||
                       ((state_q == S_REQ)   && req && bus.imem_gnt) ||
                       ((state_q == S_DRAIN) && !bus.imem_rvalid);

  // Next-state logic; a redirect overrides every normal transition.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_REQ: begin
        if (req && bus.imem_gnt) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (bus.imem_rvalid) state_d = stall_in ? S_HOLD : S_REQ;
      end
      S_HOLD: begin
        if (!stall_in) state_d = S_REQ;
      end
      S_DRAIN: begin
        if (bus.imem_rvalid) state_d = S_REQ;
      end
      default: state_d = S_REQ;
    endcase
    if (redir_valid) state_d = outstanding ? S_DRAIN : S_REQ;
  end

  // Datapath next values: PC, output register, stall buffer, misalign flag.
  always_comb begin
    pc_d       = pc_q;
    // Nothing loaded: drop valid unless IF/ID is holding.
    vld_d      = stall_in ? vld_q : 1'b0;
    out_d      = out_q;
    ipc_d      = ipc_q;
    buf_inst_d = buf_inst_q;
    buf_pc_d   = buf_pc_q;
`ifdef FETCH_ALIGN_CHECK_EN
    mis_d      = mis_q;
`endif

    if ((state_q == S_WAIT) && bus.imem_rvalid) begin
      pc_d = pc_inc;
      if (stall_in) begin
        buf_inst_d = bus.imem_rdata;
        buf_pc_d   = pc_q;
      end else begin
        vld_d = 1'b1;
        out_d = bus.imem_rdata;
        ipc_d = pc_q;
      end
    end

    if ((state_q == S_HOLD) && !stall_in) begin
      vld_d = 1'b1;
      out_d = buf_inst_q;
      ipc_d = buf_pc_q;
    end

    // Redirect kills whatever is in flight, buffered or presented.
    if (redir_valid) begin
      pc_d       = redir_tgt;
      vld_d      = 1'b0;
      buf_inst_d = 32'h0000_0000;
      buf_pc_d   = 32'h0000_0000;
`ifdef FETCH_ALIGN_CHECK_EN
      mis_d      = redir_mis;
`endif
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst) state_q <= S_REQ;
    else      state_q <= state_d;
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q       <= RESET_PC;
      vld_q      <= 1'b0;
      out_q      <= NOP;
      ipc_q      <= 32'h0000_0000;
      buf_inst_q <= 32'h0000_0000;
      buf_pc_q   <= 32'h0000_0000;
`ifdef FETCH_ALIGN_CHECK_EN
      mis_q      <= 1'b0;
`endif
    end else begin
      pc_q       <= pc_d;
      vld_q      <= vld_d;
      out_q      <= out_d;
      ipc_q      <= ipc_d;
      buf_inst_q <= buf_inst_d;
      buf_pc_q   <= buf_pc_d;
`ifdef FETCH_ALIGN_CHECK_EN
      mis_q      <= mis_d;
`endif
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Directed testbench for if_fetch. Memory data is addr ^ A5A5_A5A5.
// A second instance starts at 32'hFFFF_FFFC to cover PC wrap-around.
module tb_if_fetch;
  localparam logic [31:0] KEY = 32'hA5A5_A5A5;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_in;
  logic        redir_valid;
  logic [31:0] redir_pc;

  logic        inst_valid, w_inst_valid;
  logic [31:0] inst_out, w_inst_out;
  logic [31:0] inst_pc, w_inst_pc;
  logic        fetch_misalign, w_fetch_misalign;

  logic [31:0] pend, w_pend;
  int total = 0;
  int bad   = 0;

  if_fetch_if bus ();
  if_fetch_if wbus ();

  if_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rst            (rst),
    .stall_in       (stall_in),
    .redir_valid    (redir_valid),
    .redir_pc       (redir_pc),
    .bus            (bus),
    .inst_valid     (inst_valid),
    .inst_out       (inst_out),
    .inst_pc        (inst_pc),
    .fetch_misalign (fetch_misalign)
  );

  if_fetch #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk            (clk),
    .rst            (rst),
    .stall_in       (stall_in),
    .redir_valid    (redir_valid),
    .redir_pc       (redir_pc),
    .bus            (wbus),
    .inst_valid     (w_inst_valid),
    .inst_out       (w_inst_out),
    .inst_pc        (w_inst_pc),
    .fetch_misalign (w_fetch_misalign)
  );

  always #5 clk = ~clk;

  // One cycle of stimulus: inputs set at negedge, outputs settle at posedge+1.
  task automatic drive(input logic g, input logic rv, input logic st,
                       input logic rd, input logic [31:0] rpc);
    @(negedge clk);
    bus.imem_gnt     = g;
    bus.imem_rvalid  = rv;
    bus.imem_rdata   = rv ? (pend ^ KEY) : 32'hDEAD_BEEF;
    if (g && bus.imem_req) pend = bus.imem_addr;
    wbus.imem_gnt    = g;
    wbus.imem_rvalid = rv;
    wbus.imem_rdata  = rv ? (w_pend ^ KEY) : 32'hDEAD_BEEF;
    if (g && wbus.imem_req) w_pend = wbus.imem_addr;
    stall_in    = st;
    redir_valid = rd;
    redir_pc    = rpc;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    bus.imem_gnt = 1'b0;  bus.imem_rvalid = 1'b0;  bus.imem_rdata = 32'h0;
    wbus.imem_gnt = 1'b0; wbus.imem_rvalid = 1'b0; wbus.imem_rdata = 32'h0;
    stall_in = 1'b0; redir_valid = 1'b0; redir_pc = 32'h0;
    pend = 32'h0; w_pend = 32'h0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b0;
    bus.imem_gnt = 1'b1;  bus.imem_rvalid = 1'b1;  bus.imem_rdata = 32'h1234_5678;
    wbus.imem_gnt = 1'b1; wbus.imem_rvalid = 1'b1; wbus.imem_rdata = 32'h1234_5678;
    stall_in = 1'b1; redir_valid = 1'b1; redir_pc = 32'h300;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({bus.imem_req, bus.imem_addr, inst_valid, inst_out, inst_pc, fetch_misalign} !==
        {1'b1, 32'h0, 1'b0, 32'h0000_0013, 32'h0, 1'b0}) begin
      bad++;
      $display("FAIL reset_state: got req=%b addr=%h v=%b out=%h pc=%h mis=%b, want 1 00000000 0 00000013 00000000 0",
               bus.imem_req, bus.imem_addr, inst_valid, inst_out, inst_pc, fetch_misalign);
    end
    total++;
    if ({wbus.imem_req, wbus.imem_addr, w_inst_valid} !== {1'b1, 32'hFFFF_FFFC, 1'b0}) begin
      bad++;
      $display("FAIL reset_wrap_pc: got req=%b addr=%h v=%b, want 1 fffffffc 0",
               wbus.imem_req, wbus.imem_addr, w_inst_valid);
    end
  endtask

  task automatic test_sequential();
    logic [31:0] a;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      a = 32'(i * 4);
      drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      total++;
      if ({inst_valid, bus.imem_req} !== 2'b00) begin
        bad++;
        $display("FAIL seq_wait[%0d]: got v=%b req=%b, want 0 0", i, inst_valid, bus.imem_req);
      end
      drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
      total++;
      if ({inst_valid, inst_pc, inst_out, bus.imem_req, bus.imem_addr} !==
          {1'b1, a, a ^ KEY, 1'b1, a + 32'd4}) begin
        bad++;
        $display("FAIL seq_inst[%0d]: got v=%b pc=%h out=%h req=%b addr=%h, want 1 %h %h 1 %h",
                 i, inst_valid, inst_pc, inst_out, bus.imem_req, bus.imem_addr, a, a ^ KEY, a + 32'd4);
      end
    end
  endtask

  task automatic test_stall();
    do_reset();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    total++;
    if ({inst_valid, inst_pc, inst_out} !== {1'b1, 32'h4, 32'h4 ^ KEY}) begin
      bad++;
      $display("FAIL stall_keep_valid: got v=%b pc=%h out=%h, want 1 00000004 %h",
               inst_valid, inst_pc, inst_out, 32'h4 ^ KEY);
    end
    drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      total++;
      if ({inst_valid, inst_pc, inst_out, bus.imem_req} !== {1'b1, 32'h4, 32'h4 ^ KEY, 1'b0}) begin
        bad++;
        $display("FAIL stall_frozen[%0d]: got v=%b pc=%h out=%h req=%b, want 1 00000004 %h 0",
                 i, inst_valid, inst_pc, inst_out, bus.imem_req, 32'h4 ^ KEY);
      end
      if (i < 2) drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    end
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    total++;
    if ({inst_valid, inst_pc, inst_out, bus.imem_req, bus.imem_addr} !==
        {1'b1, 32'h8, 32'h8 ^ KEY, 1'b1, 32'hC}) begin
      bad++;
      $display("FAIL stall_release: got v=%b pc=%h out=%h req=%b addr=%h, want 1 00000008 %h 1 0000000c",
               inst_valid, inst_pc, inst_out, bus.imem_req, bus.imem_addr, 32'h8 ^ KEY);
    end
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    total++;
    if ({inst_valid, inst_pc, inst_out} !== {1'b1, 32'hC, 32'hC ^ KEY}) begin
      bad++;
      $display("FAIL stall_next: got v=%b pc=%h out=%h, want 1 0000000c %h",
               inst_valid, inst_pc, inst_out, 32'hC ^ KEY);
    end
  endtask

  task automatic test_redirect_wait();
    do_reset();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 32'h100);
    total++;
    if ({inst_valid, bus.imem_req} !== 2'b00) begin
      bad++;
      $display("FAIL redir_wait_clear: got v=%b req=%b, want 0 0", inst_valid, bus.imem_req);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    total++;
    if ({inst_valid, bus.imem_req} !== 2'b00) begin
      bad++;
      $display("FAIL redir_draining: got v=%b req=%b, want 0 0", inst_valid, bus.imem_req);
    end
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    total++;
    if ({inst_valid, bus.imem_req, bus.imem_addr} !== {1'b0, 1'b1, 32'h100}) begin
      bad++;
      $display("FAIL redir_after_drain: got v=%b req=%b addr=%h, want 0 1 00000100",
               inst_valid, bus.imem_req, bus.imem_addr);
    end
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    total++;
    if ({inst_valid, inst_pc, inst_out} !== {1'b1, 32'h100, 32'h100 ^ KEY}) begin
      bad++;
      $display("FAIL redir_target_inst: got v=%b pc=%h out=%h, want 1 00000100 %h",
               inst_valid, inst_pc, inst_out, 32'h100 ^ KEY);
    end
  endtask

  task automatic test_redirect_rvalid();
    do_reset();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h200);
    total++;
    if ({inst_valid, bus.imem_req, bus.imem_addr} !== {1'b0, 1'b1, 32'h200}) begin
      bad++;
      $display("FAIL redir_rvalid_drop: got v=%b req=%b addr=%h, want 0 1 00000200",
               inst_valid, bus.imem_req, bus.imem_addr);
    end
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    total++;
    if ({inst_valid, inst_pc, inst_out} !== {1'b1, 32'h200, 32'h200 ^ KEY}) begin
      bad++;
      $display("FAIL redir_rvalid_target: got v=%b pc=%h out=%h, want 1 00000200 %h",
               inst_valid, inst_pc, inst_out, 32'h200 ^ KEY);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    total++;
    if ({w_inst_valid, w_inst_pc, w_inst_out, wbus.imem_req, wbus.imem_addr} !==
        {1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC ^ KEY, 1'b1, 32'h0}) begin
      bad++;
      $display("FAIL wrap_first: got v=%b pc=%h out=%h req=%b addr=%h, want 1 fffffffc %h 1 00000000",
               w_inst_valid, w_inst_pc, w_inst_out, wbus.imem_req, wbus.imem_addr, 32'hFFFF_FFFC ^ KEY);
    end
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    total++;
    if ({w_inst_valid, w_inst_pc, w_inst_out} !== {1'b1, 32'h0, KEY}) begin
      bad++;
      $display("FAIL wrap_second: got v=%b pc=%h out=%h, want 1 00000000 %h",
               w_inst_valid, w_inst_pc, w_inst_out, KEY);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b0;
    wbus.imem_gnt = 1'b0; wbus.imem_rvalid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    pend = 32'h0; w_pend = 32'h0;
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    total++;
    if ({bus.imem_req, bus.imem_addr, inst_valid} !== {1'b1, 32'h0, 1'b0}) begin
      bad++;
      $display("FAIL mid_reset_stale: got req=%b addr=%h v=%b, want 1 00000000 0",
               bus.imem_req, bus.imem_addr, inst_valid);
    end
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    total++;
    if ({inst_valid, inst_pc, inst_out} !== {1'b1, 32'h0, KEY}) begin
      bad++;
      $display("FAIL mid_reset_refetch: got v=%b pc=%h out=%h, want 1 00000000 %h",
               inst_valid, inst_pc, inst_out, KEY);
    end
  endtask

  task automatic test_misalign();
    do_reset();
    drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h102);
`ifdef FETCH_ALIGN_CHECK_EN
    total++;
    if ({fetch_misalign, bus.imem_req, inst_valid} !== 3'b100) begin
      bad++;
      $display("FAIL misalign_set: got mis=%b req=%b v=%b, want 1 0 0", fetch_misalign, bus.imem_req, inst_valid);
    end
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    total++;
    if ({fetch_misalign, bus.imem_req} !== 2'b10) begin
      bad++;
      $display("FAIL misalign_idle: got mis=%b req=%b, want 1 0", fetch_misalign, bus.imem_req);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h200);
    total++;
    if ({fetch_misalign, bus.imem_req, bus.imem_addr} !== {1'b0, 1'b1, 32'h200}) begin
      bad++;
      $display("FAIL misalign_clear: got mis=%b req=%b addr=%h, want 0 1 00000200",
               fetch_misalign, bus.imem_req, bus.imem_addr);
    end
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    total++;
    if ({inst_valid, inst_pc, inst_out} !== {1'b1, 32'h200, 32'h200 ^ KEY}) begin
      bad++;
      $display("FAIL misalign_resume: got v=%b pc=%h out=%h, want 1 00000200 %h",
               inst_valid, inst_pc, inst_out, 32'h200 ^ KEY);
    end
`else
    total++;
    if ({fetch_misalign, bus.imem_req, bus.imem_addr} !== {1'b0, 1'b1, 32'h100}) begin
      bad++;
      $display("FAIL align_force: got mis=%b req=%b addr=%h, want 0 1 00000100",
               fetch_misalign, bus.imem_req, bus.imem_addr);
    end
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    total++;
    if ({inst_valid, inst_pc, inst_out, fetch_misalign} !== {1'b1, 32'h100, 32'h100 ^ KEY, 1'b0}) begin
      bad++;
      $display("FAIL align_fetch: got v=%b pc=%h out=%h mis=%b, want 1 00000100 %h 0",
               inst_valid, inst_pc, inst_out, fetch_misalign, 32'h100 ^ KEY);
    end
`endif
  endtask

  initial begin
    rst = 1'b0;
    stall_in = 1'b0; redir_valid = 1'b0; redir_pc = 32'h0;
    pend = 32'h0; w_pend = 32'h0;
    test_reset();
    test_sequential();
    test_stall();
    test_redirect_wait();
    test_redirect_rvalid();
    test_wrap();
    test_reset_mid();
    test_misalign();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
endmodule

// File: doc/if_fetch.md
# if_fetch

Instruction-fetch stage of the xRV32I pipeline. Holds the program counter and issues one-outstanding-request reads to instruction memory. Handles stalls with a one-entry response buffer and branch/jump redirects with kill of in-flight responses. Its registered outputs `inst_valid`/`inst_out`/`inst_pc` drive the IF/ID pipeline register directly downstream.

## Interface
- `RESET_PC`, 32'h0000_0000, PC loaded on reset
- `clk`  in  1  core clock, all state on rising edge
- `rst`  in  1  synchronous reset, active-low (`RstEnable` = 1'b0)
- `stall_in`  in  1  hazard unit holds IF/ID; output register must not change
- `redir_valid`  in  1  redirect request from EX (branch taken / jump)
- `redir_pc`  in  32  redirect target
- `imem_req`  out  1  fetch request, asserted only in REQ
- `imem_addr`  out  32  fetch address, equals `pc`
- `imem_gnt`  in  1  memory accepted request this cycle
- `imem_rvalid`  in  1  read data valid (≥1 cycle after grant)
- `imem_rdata`  in  32  instruction word
- `inst_valid`  out  1  `inst_out`/`inst_pc` hold a live instruction
- `inst_out`  out  32  fetched instruction
- `inst_pc`  out  32  PC of `inst_out`
- `fetch_misalign`  out  1  only with `FETCH_ALIGN_CHECK_EN`; else tied 0

## Operation
- State: `pc`[31:0], FSM {REQ, WAIT, HOLD, DRAIN}, output reg (`inst_valid`,`inst_out`,`inst_pc`), buffer (`buf_inst`,`buf_pc`).
- Reset: `pc`=RESET_PC, state REQ, `inst_valid`=0, `inst_out`=32'h0000_0013 (NOP), `inst_pc`=0, buffer cleared, `fetch_misalign`=0.
- REQ: `imem_req`=1, `imem_addr`=`pc`. On `imem_gnt` → WAIT.
- WAIT: on `imem_rvalid`:
  - `stall_in`=0: output reg ← {1, rdata, pc}; `pc`←pc+4; → REQ.
  - `stall_in`=1: buffer ← {rdata, pc}; `pc`←pc+4; → HOLD.
- HOLD: `imem_req`=0. When `stall_in`=0: output reg ← {1, buffer}; → REQ.
- DRAIN: `imem_req`=0. On `imem_rvalid` the response is discarded; → REQ.
- Output reg when nothing is loaded: `stall_in`=0 → `inst_valid`←0; `stall_in`=1 → unchanged.
- Redirect has highest priority and overrides every rule above.
  - `pc`←`redir_pc`; `inst_valid`←0; buffer invalidated.
  - Next state is DRAIN if a request is still outstanding after this edge: WAIT without rvalid, REQ with gnt, or DRAIN without rvalid.
  - Otherwise the next state is REQ. This covers a same-cycle rvalid, which is discarded.
- Redirect in REQ without gnt withdraws the old address. The memory interface tolerates the address change.
- PC arithmetic: 32-bit modulo; 32'hFFFF_FFFC+4 wraps to 0.
- At most one outstanding request at all times.

## Timing
- Best-case fetch: REQ+gnt at cycle N, rvalid at N+1, `inst_valid`=1 at N+2, next `imem_req` at N+2.
- Throughput: one instruction per 2 cycles with 1-cycle memory.
- Redirect at edge N: `inst_valid`=0 from N. The first fetch of `redir_pc` is requested at N if not draining, else the cycle after the killed rvalid.
- `inst_*` outputs never change while `stall_in`=1, except for the clear on redirect.
- Reset asserted mid-transaction: all state is restored. A subsequent stale rvalid arriving in REQ is ignored.

## Configuration
- `FETCH_ALIGN_CHECK_EN` defined:
  - On redirect with `redir_pc[1:0]`≠0, `fetch_misalign`←1 and `pc`←`redir_pc`.
  - The FSM goes to HOLD-like idle with no request until the next redirect or reset, either of which clears the flag.
- Undefined:
  - `pc`←{`redir_pc`[31:2],2'b00}.
  - `fetch_misalign` constant 0.

## Test plan
- Reset release, memory grants immediately, 1-cycle rvalid, data = addr^32'hA5A5_A5A5 -> `inst_pc` sequence 0,4,8 with matching `inst_out`, `inst_valid` every 2nd cycle.
- Hold `stall_in`=1 from the cycle rvalid arrives for pc=8 for 3 cycles -> outputs frozen at pc=4. On release, pc=8 is presented next, no instruction lost or duplicated.
- `redir_valid` with `redir_pc`=32'h100 while in WAIT, rvalid 2 cycles later -> the killed word is never presented, `imem_addr`=32'h100 after drain, next `inst_pc`=32'h100.
- Redirect coinciding with rvalid -> the word is dropped, `inst_valid`=0 next cycle, REQ for the target issued immediately.
- Start `RESET_PC`=32'hFFFF_FFFC -> second fetch address 0.
- With `FETCH_ALIGN_CHECK_EN`, redirect to 32'h102 -> `fetch_misalign`=1, `imem_req`=0. Redirect to 32'h200 -> flag clears, fetch resumes at 32'h200. Without the macro, 32'h102 fetches from 32'h100.
